// File: rtl/sram_like_arbiter_if.sv
// Bus bundle for the sram-like arbiter: NUM_CH upstream channels packed into
// flat vectors plus one downstream sram-like port. The slave modport is the
// arbiter's view; the master modport is the surrounding system's view.
interface sram_like_arbiter_if #(
  parameter int NUM_CH = 2
);
  // upstream (core side) channels
  logic [NUM_CH-1:0]    m_req;
  logic [NUM_CH-1:0]    m_wr;
  logic [2*NUM_CH-1:0]  m_size;
  logic [4*NUM_CH-1:0]  m_wstrb;
  logic [32*NUM_CH-1:0] m_addr;
  logic [32*NUM_CH-1:0] m_wdata;
  logic [NUM_CH-1:0]    m_addr_ok;
  logic [NUM_CH-1:0]    m_data_ok;
  logic [32*NUM_CH-1:0] m_rdata;

  // downstream (bridge/memory side) port
  logic        s_req;
  logic        s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_addr_ok;
  logic        s_data_ok;
  logic [31:0] s_rdata;

  modport slave (
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  s_addr_ok, s_data_ok, s_rdata,
    output m_addr_ok, m_data_ok, m_rdata,
    output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
  );

  modport master (
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output s_addr_ok, s_data_ok, s_rdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Merges NUM_CH sram-like request channels onto one downstream port.
// Issued channel IDs are kept in an in-order FIFO so every downstream
// data_ok is steered back to the channel that made the request.
module sram_like_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 4,
  parameter int RR_MODE = 0,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_arbiter_if.slave  bus,
  output logic [CW-1:0]       outstanding,
  output logic                proto_err
);

  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = $clog2(DEPTH);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

  lock_state_t    state_q, state_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           proto_err_q, proto_err_d;
  logic [IDW-1:0] fifo_q [DEPTH];

  logic [IDW-1:0] grant_id;
  logic           grant_vld;
  logic           full, s_req, hs, pop;
  logic [IDW-1:0] head_id;

  assign full    = (count_q == CW'(DEPTH));
  assign s_req   = grant_vld & ~full;
  assign hs      = s_req & bus.s_addr_ok;
  // a data_ok with nothing outstanding (even if a push lands this cycle) is an error, not a pop
  assign pop     = bus.s_data_ok & (count_q != '0);
  assign head_id = fifo_q[head_q];

  assign outstanding = count_q;
  assign proto_err   = proto_err_q;
  assign bus.s_req   = s_req;

  // grant selection: a pending (locked) request always keeps the grant
  always_comb begin
    grant_id  = '0;
    grant_vld = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant_id  = lock_id_q;
      grant_vld = bus.m_req[lock_id_q];
    end else if (RR_MODE == 0) begin
      // ascending scan, last hit wins -> highest index has priority
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.m_req[i]) begin
          grant_id  = IDW'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      // descending offset scan, last hit wins -> first requester at/after rr_q
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (bus.m_req[(int'(rr_q) + k) % NUM_CH]) begin
          grant_id  = IDW'((int'(rr_q) + k) % NUM_CH);
          grant_vld = 1'b1;
        end
      end
    end
  end

  // downstream request fields follow the granted channel, zero otherwise
  always_comb begin
    bus.s_wr    = 1'b0;
    bus.s_size  = '0;
    bus.s_wstrb = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    if (grant_vld) begin
      bus.s_wr    = bus.m_wr[grant_id];
      bus.s_size  = bus.m_size[2*int'(grant_id) +: 2];
      bus.s_wstrb = bus.m_wstrb[4*int'(grant_id) +: 4];
      bus.s_addr  = bus.m_addr[32*int'(grant_id) +: 32];
      bus.s_wdata = bus.m_wdata[32*int'(grant_id) +: 32];
    end
  end

  // per-channel handshake strobes; read data is broadcast, data_ok selects
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign bus.m_addr_ok[gi]         = hs  & (grant_id == IDW'(gi));
    assign bus.m_data_ok[gi]         = pop & (head_id  == IDW'(gi));
    assign bus.m_rdata[32*gi +: 32]  = bus.s_rdata;
  end

  // lock FSM next state: hold the grant from first unaccepted request until handshake
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      ST_OPEN: begin
        if (s_req && !bus.s_addr_ok) begin
          state_d   = ST_LOCKED;
          lock_id_d = grant_id;
        end
      end
      ST_LOCKED: begin
        if (hs) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  // FIFO pointers, occupancy, round-robin pointer and sticky error next state
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rr_d        = rr_q;
    proto_err_d = proto_err_q;
    if (hs)  tail_d = tail_q + 1'b1;
    if (pop) head_d = head_q + 1'b1;
    case ({hs, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.s_data_ok && (count_q == '0)) proto_err_d = 1'b1;
    if (hs && (RR_MODE != 0))
      rr_d = (grant_id == IDW'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
  end

  // control state registers with asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_OPEN;
      lock_id_q   <= '0;
      rr_q        <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      rr_q        <= rr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // ID storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (hs) fifo_q[tail_q] <= grant_id;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a table of vectors for fill/full behaviour,
// directed sequences for lock, routing, error and reset cases, a round-robin
// sequence on a 3-channel instance, and random traffic against a queue model.
module tb_sram_like_arbiter;

  localparam int NA = 2;
  localparam int DA = 4;
  localparam int NB = 3;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_like_arbiter_if #(.NUM_CH(NA)) bus_a ();
  sram_like_arbiter_if #(.NUM_CH(NB)) bus_b ();

  logic [$clog2(DA+1)-1:0] out_a;
  logic [$clog2(DB+1)-1:0] out_b;
  logic err_a, err_b;

  sram_like_arbiter #(.NUM_CH(NA), .DEPTH(DA), .RR_MODE(0)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a), .outstanding(out_a), .proto_err(err_a));

  sram_like_arbiter #(.NUM_CH(NB), .DEPTH(DB), .RR_MODE(1)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b), .outstanding(out_b), .proto_err(err_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic [1:0] req, input logic aok, input logic dok,
                         input logic [31:0] rd);
    bus_a.m_req     = req;
    bus_a.s_addr_ok = aok;
    bus_a.s_data_ok = dok;
    bus_a.s_rdata   = rd;
  endtask

  // advance one cycle: sample point is the negedge, drive point is posedge+1
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // reference grant choice from the priority rules
  function automatic int pick(input logic [7:0] req, input int n, input bit rr, input int ptr);
    if (!rr) begin
      for (int i = n - 1; i >= 0; i--) if (req[i]) return i;
      return -1;
    end
    for (int k = 0; k < n; k++) if (req[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  typedef struct {
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic        e_sreq;
    logic [1:0]  e_aok;
    logic [1:0]  e_dok;
    int          e_out;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt [11];

  // random-phase model state
  int          mq[$];
  int          pend;
  bit          merr;
  logic [31:0] r_addr  [NA];
  logic [31:0] r_wdata [NA];
  logic [1:0]  r_size  [NA];
  logic [3:0]  r_wstrb [NA];
  logic        r_wr    [NA];

  initial begin
    logic [2:0] b_aok_exp [5];
    logic [2:0] b_dok_exp [5];

    // fill to full with channel 1 winning, pop while full, then drain
    vt[0]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 0, 32'h200};
    vt[1]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1, 32'h200};
    vt[2]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 2, 32'h200};
    vt[3]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 3, 32'h200};
    vt[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4, 32'h200};
    vt[5]  = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 4, 32'h200};
    vt[6]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 3, 32'h200};
    vt[7]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 4, 32'h0};
    vt[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 3, 32'h0};
    vt[9]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2, 32'h0};
    vt[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 1, 32'h0};

    b_aok_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    b_dok_exp = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};

    bus_a.m_req = '0; bus_a.m_wr = 2'b10; bus_a.m_size = {2'd1, 2'd2};
    bus_a.m_wstrb = {4'h3, 4'hF}; bus_a.m_addr = {32'h200, 32'h100};
    bus_a.m_wdata = {32'hD1, 32'hD0};
    bus_a.s_addr_ok = 1'b0; bus_a.s_data_ok = 1'b0; bus_a.s_rdata = '0;
    bus_b.m_req = '0; bus_b.m_wr = '0; bus_b.m_size = '0; bus_b.m_wstrb = '0;
    bus_b.m_addr = {32'h2000, 32'h1000, 32'h0}; bus_b.m_wdata = '0;
    bus_b.s_addr_ok = 1'b0; bus_b.s_data_ok = 1'b0; bus_b.s_rdata = '0;

    // ---------------- reset state ----------------
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outstanding", 64'(out_a), 64'd0);
    chk("rst_proto_err", 64'(err_a), 64'd0);
    chk("rst_s_req", 64'(bus_a.s_req), 64'd0);
    chk("rst_m_addr_ok", 64'(bus_a.m_addr_ok), 64'd0);
    chk("rst_m_data_ok", 64'(bus_a.m_data_ok), 64'd0);
    @(negedge clk) resetn = 1'b1;
    next_cycle();

    // ---------------- table: fill, full, pop-while-full, drain ----------------
    for (int v = 0; v < 11; v++) begin
      drive_a(vt[v].req, vt[v].aok, vt[v].dok, 32'h0);
      @(negedge clk);
      $display("vec %0d: req=%b aok=%b dok=%b -> s_req=%b m_addr_ok=%b m_data_ok=%b out=%0d",
               v, vt[v].req, vt[v].aok, vt[v].dok, bus_a.s_req, bus_a.m_addr_ok,
               bus_a.m_data_ok, out_a);
      chk($sformatf("vec%0d_s_req", v), 64'(bus_a.s_req), 64'(vt[v].e_sreq));
      chk($sformatf("vec%0d_m_addr_ok", v), 64'(bus_a.m_addr_ok), 64'(vt[v].e_aok));
      chk($sformatf("vec%0d_m_data_ok", v), 64'(bus_a.m_data_ok), 64'(vt[v].e_dok));
      chk($sformatf("vec%0d_outstanding", v), 64'(out_a), 64'(vt[v].e_out));
      chk($sformatf("vec%0d_s_addr", v), 64'(bus_a.s_addr), 64'(vt[v].e_addr));
      next_cycle();
    end
    drive_a(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("drained_outstanding", 64'(out_a), 64'd0);
    next_cycle();

    // ---------------- lock: pending ch0 is not preempted by ch1 ----------------
    drive_a(2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("lock_c0_s_addr", 64'(bus_a.s_addr), 64'h100);
    chk("lock_c0_s_req", 64'(bus_a.s_req), 64'd1);
    chk("lock_c0_m_addr_ok", 64'(bus_a.m_addr_ok), 64'd0);
    next_cycle();
    for (int c = 1; c < 3; c++) begin
      drive_a(2'b11, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("lock_c%0d_s_addr", c), 64'(bus_a.s_addr), 64'h100);
      next_cycle();
    end
    drive_a(2'b11, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("lock_c3_m_addr_ok", 64'(bus_a.m_addr_ok), 64'b01);
    chk("lock_c3_s_addr", 64'(bus_a.s_addr), 64'h100);
    next_cycle();
    drive_a(2'b10, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("lock_c4_m_addr_ok", 64'(bus_a.m_addr_ok), 64'b10);
    chk("lock_c4_s_addr", 64'(bus_a.s_addr), 64'h200);
    chk("lock_c4_s_wr", 64'(bus_a.s_wr), 64'd1);
    next_cycle();
    drive_a(2'b00, 1'b0, 1'b1, 32'h55);
    @(negedge clk);
    chk("lock_ret0_m_data_ok", 64'(bus_a.m_data_ok), 64'b01);
    chk("lock_ret0_rdata", 64'(bus_a.m_rdata[31:0]), 64'h55);
    next_cycle();
    drive_a(2'b00, 1'b0, 1'b1, 32'h66);
    @(negedge clk);
    chk("lock_ret1_m_data_ok", 64'(bus_a.m_data_ok), 64'b10);
    chk("lock_ret1_rdata", 64'(bus_a.m_rdata[63:32]), 64'h66);
    next_cycle();

    // ---------------- routing and simultaneous push/pop ----------------
    bus_a.m_addr[31:0] = 32'h100;
    drive_a(2'b01, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("route_i0_m_addr_ok", 64'(bus_a.m_addr_ok), 64'b01);
    next_cycle();
    bus_a.m_addr[63:32] = 32'h200;
    drive_a(2'b10, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("route_i1_m_addr_ok", 64'(bus_a.m_addr_ok), 64'b10);
    next_cycle();
    bus_a.m_addr[31:0] = 32'h300;
    drive_a(2'b01, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("route_i2_s_addr", 64'(bus_a.s_addr), 64'h300);
    next_cycle();
    drive_a(2'b00, 1'b0, 1'b1, 32'hA);
    @(negedge clk);
    chk("route_r0_outstanding", 64'(out_a), 64'd3);
    chk("route_r0_m_data_ok", 64'(bus_a.m_data_ok), 64'b01);
    chk("route_r0_rdata", 64'(bus_a.m_rdata[31:0]), 64'hA);
    next_cycle();
    bus_a.m_addr[63:32] = 32'h400;
    drive_a(2'b10, 1'b1, 1'b1, 32'hB);
    @(negedge clk);
    chk("simul_outstanding_before", 64'(out_a), 64'd2);
    chk("simul_m_data_ok", 64'(bus_a.m_data_ok), 64'b10);
    chk("simul_m_addr_ok", 64'(bus_a.m_addr_ok), 64'b10);
    chk("simul_rdata", 64'(bus_a.m_rdata[63:32]), 64'hB);
    next_cycle();
    drive_a(2'b00, 1'b0, 1'b1, 32'hC);
    @(negedge clk);
    chk("simul_outstanding_after", 64'(out_a), 64'd2);
    chk("route_r2_m_data_ok", 64'(bus_a.m_data_ok), 64'b01);
    chk("route_r2_rdata", 64'(bus_a.m_rdata[31:0]), 64'hC);
    next_cycle();
    drive_a(2'b00, 1'b0, 1'b1, 32'hD);
    @(negedge clk);
    chk("route_r3_m_data_ok", 64'(bus_a.m_data_ok), 64'b10);
    chk("route_r3_rdata", 64'(bus_a.m_rdata[63:32]), 64'hD);
    next_cycle();

    // ---------------- data_ok while empty ----------------
    drive_a(2'b00, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk("empty_outstanding", 64'(out_a), 64'd0);
    chk("empty_m_data_ok", 64'(bus_a.m_data_ok), 64'd0);
    chk("empty_err_before", 64'(err_a), 64'd0);
    next_cycle();
    drive_a(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("empty_err_set", 64'(err_a), 64'd1);
    chk("empty_outstanding_after", 64'(out_a), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("empty_err_sticky", 64'(err_a), 64'd1);
    next_cycle();

    // ---------------- asynchronous reset mid-burst ----------------
    for (int c = 0; c < 3; c++) begin
      drive_a(2'b10, 1'b1, 1'b0, 32'h0);
      next_cycle();
    end
    drive_a(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("burst_outstanding", 64'(out_a), 64'd3);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_outstanding", 64'(out_a), 64'd0);
    chk("async_rst_proto_err", 64'(err_a), 64'd0);
    @(negedge clk) resetn = 1'b1;
    next_cycle();
    drive_a(2'b00, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk("post_rst_m_data_ok", 64'(bus_a.m_data_ok), 64'd0);
    next_cycle();
    drive_a(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("post_rst_err", 64'(err_a), 64'd1);
    resetn = 1'b0;
    next_cycle();
    @(negedge clk) resetn = 1'b1;
    next_cycle();

    // ---------------- round-robin on the 3-channel instance ----------------
    for (int c = 0; c < 5; c++) begin
      bus_b.m_req = 3'b111;
      bus_b.s_addr_ok = 1'b1;
      bus_b.s_data_ok = (c != 0);
      @(negedge clk);
      $display("rr cycle %0d: m_addr_ok=%b m_data_ok=%b s_addr=%h",
               c, bus_b.m_addr_ok, bus_b.m_data_ok, bus_b.s_addr);
      chk($sformatf("rr%0d_m_addr_ok", c), 64'(bus_b.m_addr_ok), 64'(b_aok_exp[c]));
      chk($sformatf("rr%0d_m_data_ok", c), 64'(bus_b.m_data_ok), 64'(b_dok_exp[c]));
      next_cycle();
    end
    bus_b.m_req = '0; bus_b.s_addr_ok = 1'b0; bus_b.s_data_ok = 1'b0;
    @(negedge clk);
    chk("rr_err_clear", 64'(err_b), 64'd0);
    next_cycle();

    // ---------------- random traffic against queue model ----------------
    mq.delete();
    pend = -1;
    merr = 1'b0;
    for (int t = 0; t < 400; t++) begin
      logic [1:0]  req;
      logic        aok, dok, full, e_sreq, hs, pop;
      logic [31:0] rd;
      logic [1:0]  e_aok, e_dok;
      int          w, pre_size;
      req = 2'($urandom_range(0, 3));
      aok = ($urandom_range(0, 1) == 1);
      dok = ($urandom_range(0, 1) == 1);
      rd  = $urandom;
      for (int i = 0; i < NA; i++) begin
        r_addr[i]  = $urandom;
        r_wdata[i] = $urandom;
        r_size[i]  = 2'($urandom_range(0, 3));
        r_wstrb[i] = 4'($urandom_range(0, 15));
        r_wr[i]    = 1'($urandom_range(0, 1));
        bus_a.m_addr[32*i +: 32]  = r_addr[i];
        bus_a.m_wdata[32*i +: 32] = r_wdata[i];
        bus_a.m_size[2*i +: 2]    = r_size[i];
        bus_a.m_wstrb[4*i +: 4]   = r_wstrb[i];
        bus_a.m_wr[i]             = r_wr[i];
      end
      drive_a(req, aok, dok, rd);

      pre_size = mq.size();
      w      = (pend >= 0) ? pend : pick(8'(req), NA, 1'b0, 0);
      full   = (pre_size == DA);
      e_sreq = (w >= 0) && req[w] && !full;
      hs     = e_sreq && aok;
      e_aok  = hs ? 2'(1 << w) : 2'b00;
      pop    = dok && (pre_size > 0);
      e_dok  = pop ? 2'(1 << mq[0]) : 2'b00;

      @(negedge clk);
      chk("rnd_s_req", 64'(bus_a.s_req), 64'(e_sreq));
      chk("rnd_m_addr_ok", 64'(bus_a.m_addr_ok), 64'(e_aok));
      chk("rnd_m_data_ok", 64'(bus_a.m_data_ok), 64'(e_dok));
      chk("rnd_outstanding", 64'(out_a), 64'(pre_size));
      chk("rnd_proto_err", 64'(err_a), 64'(merr));
      chk("rnd_m_rdata", 64'(bus_a.m_rdata), 64'({rd, rd}));
      if ((w >= 0) && req[w]) begin
        chk("rnd_s_addr", 64'(bus_a.s_addr), 64'(r_addr[w]));
        chk("rnd_s_wdata", 64'(bus_a.s_wdata), 64'(r_wdata[w]));
        chk("rnd_s_ctrl", 64'({bus_a.s_wr, bus_a.s_size, bus_a.s_wstrb}),
            64'({r_wr[w], r_size[w], r_wstrb[w]}));
      end else begin
        chk("rnd_s_fields_idle", 64'({bus_a.s_wr, bus_a.s_size, bus_a.s_wstrb, bus_a.s_addr}),
            64'd0);
      end

      if (pop) void'(mq.pop_front());
      if (hs) mq.push_back(w);
      if (hs) pend = -1;
      else if (e_sreq) pend = w;
      if (dok && (pre_size == 0)) merr = 1'b1;
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
